coin_acceptor: RTL and testbench

//  Coin intake front end for drink_machine_top. Takes coins from the coin mechanism and

---
 rtl/coin_pkg.sv | 27 ++
 rtl/coin_acceptor_if.sv | 25 ++
 rtl/coin_fifo.sv | 42 ++++
 rtl/coin_acceptor.sv | 132 +++++++++++++
 tb/tb_coin_acceptor.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/coin_pkg.sv
// Shared types for the coin acceptor: coin encodings, their nickel values and FSM states.
package coin_pkg;

  typedef enum logic [1:0] {
    NICKEL  = 2'b00,
    DIME    = 2'b01,
    QUARTER = 2'b10,
    SLUG    = 2'b11
  } coin_type_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    VEND,
    REFUND
  } acc_state_e;

  function automatic logic [2:0] coin_value(coin_type_e t);
    case (t)
      NICKEL:  return 3'd1;
      DIME:    return 3'd2;
      QUARTER: return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Coin mechanism and drink machine handshakes seen by the coin acceptor.
interface coin_acceptor_if;
  import coin_pkg::*;

  logic       coin_valid;
  coin_type_e coin_type;
  logic       coin_ready;
  logic       cancel;
  logic       vend_req;
  logic       vend_ack;
  logic [3:0] change_nickels;
  logic       refund_valid;
  logic       coin_reject;
  logic [5:0] credit;

  modport master (
    output coin_valid, coin_type, cancel, vend_ack,
    input  coin_ready, vend_req, change_nickels, refund_valid, coin_reject, credit
  );

  modport slave (
    input  coin_valid, coin_type, cancel, vend_ack,
    output coin_ready, vend_req, change_nickels, refund_valid, coin_reject, credit
  );
endinterface

// File: rtl/coin_fifo.sv
// Synchronous show-ahead FIFO; DEPTH must be a power of 2 (>= 2).
module coin_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // NOTE: non-blocking (<=) so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define valid entries, so the array can map to RAM.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin intake: buffers coins, accumulates credit in nickels, requests vends and refunds.
// Optional idle-refund timeout enabled by defining COIN_TIMEOUT_EN.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int PRICE_NICKELS  = 10,
  parameter int MAX_CREDIT     = 25,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic            clk,
  input  logic            reset,
  coin_acceptor_if.slave  bus
);

  acc_state_e state_q, state_d;
  logic [5:0] credit_q, credit_d, add_credit;
  logic       stage_valid_q;
  coin_type_e stage_type_q;
  logic       reject_q, reject_d;
  logic       fifo_full, fifo_empty, push, pop;
  logic [1:0] fifo_rdata;
  logic [6:0] sum;
  logic [3:0] refund_amt, change;
  logic       vend_req, refund_valid, timeout_fire;

  assign bus.coin_ready = !reset && !fifo_full;
  assign push           = bus.coin_valid && bus.coin_ready;

  coin_fifo #(.WIDTH(2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (bus.coin_type),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef COIN_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            idle_wait;

  // Counts only truly idle cycles with partial credit; any new coin restarts the wait.
  assign idle_wait = ((state_q == IDLE) || (state_q == ACCUM)) && (credit_q != '0) &&
                     (credit_q < 6'(PRICE_NICKELS)) && !stage_valid_q && fifo_empty && !bus.cancel;
  assign timeout_fire = idle_wait && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || push || !idle_wait) to_cnt_q <= '0;
    else                             to_cnt_q <= to_cnt_q + 1'b1;
  end
`else
  assign timeout_fire = 1'b0;
`endif

  // A popped coin sits one cycle in the stage register before it is credited or rejected.
  assign sum        = {1'b0, credit_q} + {4'b0, coin_value(stage_type_q)};
  assign refund_amt = (credit_q > 6'd15) ? 4'd15 : credit_q[3:0];

  // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    add_credit   = credit_q;
    reject_d     = 1'b0;
    pop          = 1'b0;
    vend_req     = 1'b0;
    refund_valid = 1'b0;
    change       = 4'd0;

    if (stage_valid_q) begin
      if (stage_type_q == SLUG || sum > 7'(MAX_CREDIT)) reject_d   = 1'b1;
      else                                              add_credit = sum[5:0];
    end

    case (state_q)
      IDLE, ACCUM: begin
        credit_d = add_credit;
        if (add_credit >= 6'(PRICE_NICKELS)) begin
          state_d = VEND;
        end else if (add_credit != '0 && (bus.cancel || timeout_fire)) begin
          state_d = REFUND;
        end else begin
          pop     = !fifo_empty;
          state_d = (add_credit == '0) ? IDLE : ACCUM;
        end
      end
      VEND: begin
        vend_req = 1'b1;
        change   = 4'(credit_q - 6'(PRICE_NICKELS));
        if (bus.vend_ack) begin
          credit_d = '0;
          state_d  = IDLE;
        end
      end
      REFUND: begin
        refund_valid = 1'b1;
        change       = refund_amt;
        credit_d     = credit_q - {2'b00, refund_amt};
        if (credit_q > 6'd15 && bus.cancel) state_d = REFUND;
        else                                state_d = (credit_d == '0) ? IDLE : ACCUM;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      stage_valid_q <= 1'b0;
      stage_type_q  <= NICKEL;
      reject_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      stage_valid_q <= pop;
      reject_q      <= reject_d;
      if (pop) stage_type_q <= coin_type_e'(fifo_rdata);
    end
  end

  assign bus.vend_req       = vend_req;
  assign bus.refund_valid   = refund_valid;
  assign bus.change_nickels = change;
  assign bus.coin_reject    = reject_q;
  assign bus.credit         = credit_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor; MAX_CREDIT is lowered to 12 so an overflow coin is reachable.
module tb_coin_acceptor;
  import coin_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   rej_seen = 0;

  coin_acceptor_if bus();

  coin_acceptor #(
    .PRICE_NICKELS  (10),
    .MAX_CREDIT     (12),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.coin_reject === 1'b1) rej_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_coin(coin_type_e t);
    bus.coin_valid = 1'b1;
    bus.coin_type  = t;
    for (int i = 0; i < 20; i++) begin
      if (bus.coin_ready) break;
      tick();
    end
    check("push_ready", bus.coin_ready, 1);
    tick();
    bus.coin_valid = 1'b0;
  endtask

  task automatic wait_vend(int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.vend_req) break;
      tick();
    end
    check("wait_vend", bus.vend_req, 1);
  endtask

  initial begin
    int base;
    logic stable, seen;
    int n;

    reset = 1'b1;
    bus.coin_valid = 1'b0;
    bus.coin_type  = NICKEL;
    bus.cancel     = 1'b0;
    bus.vend_ack   = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_ready", bus.coin_ready, 0);
    check("rst_vend", bus.vend_req, 0);
    check("rst_credit", bus.credit, 0);
    check("rst_change", bus.change_nickels, 0);
    check("rst_refund", bus.refund_valid, 0);
    check("rst_reject", bus.coin_reject, 0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", bus.coin_ready, 1);

    // 1: two quarters back to back, ack in third vend cycle
    push_coin(QUARTER);
    push_coin(QUARTER);
    tick();
    check("t1_credit5", bus.credit, 5);
    tick();
    check("t1_credit10", bus.credit, 10);
    check("t1_vend", bus.vend_req, 1);
    check("t1_change", bus.change_nickels, 0);
    repeat (2) tick();
    check("t1_vend_hold", bus.vend_req, 1);
    bus.vend_ack = 1'b1;
    tick();
    bus.vend_ack = 1'b0;
    check("t1_credit0", bus.credit, 0);
    check("t1_vend_drop", bus.vend_req, 0);

    // 2: quarter, dime, quarter -> 12, held vend, buffered dime
    push_coin(QUARTER);
    push_coin(DIME);
    push_coin(QUARTER);
    wait_vend(10);
    check("t2_credit", bus.credit, 12);
    check("t2_change", bus.change_nickels, 2);
    push_coin(DIME);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.vend_req !== 1'b1 || bus.change_nickels !== 4'd2 || bus.credit !== 6'd12)
        stable = 1'b0;
    end
    check("t2_stable", stable, 1);
    bus.vend_ack = 1'b1;
    tick();
    bus.vend_ack = 1'b0;
    check("t2_ack_credit", bus.credit, 0);
    check("t2_ack_change", bus.change_nickels, 0);
    tick();
    check("t2_dime_staged", bus.credit, 0);
    tick();
    check("t2_dime_credit", bus.credit, 2);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check("t2_refund", bus.refund_valid, 1);
    check("t2_refund_amt", bus.change_nickels, 2);
    tick();
    check("t2_refund_end", bus.refund_valid, 0);
    check("t2_credit_clr", bus.credit, 0);

    // 3: dime, nickel, cancel while the nickel is still in flight
    push_coin(DIME);
    push_coin(NICKEL);
    tick();
    check("t3_credit2", bus.credit, 2);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check("t3_refund", bus.refund_valid, 1);
    check("t3_change", bus.change_nickels, 3);
    check("t3_no_vend", bus.vend_req, 0);
    tick();
    check("t3_credit0", bus.credit, 0);
    check("t3_pulse", bus.refund_valid, 0);
    check("t3_change0", bus.change_nickels, 0);

    // 4: fill FIFO during vend, then slug and overflow rejects
    push_coin(QUARTER);
    push_coin(QUARTER);
    wait_vend(10);
    push_coin(SLUG);
    push_coin(DIME);
    push_coin(DIME);
    push_coin(QUARTER);
    check("t4_full", bus.coin_ready, 0);
    bus.coin_valid = 1'b1;
    bus.coin_type  = QUARTER;
    repeat (3) tick();
    check("t4_still_full", bus.coin_ready, 0);
    check("t4_vend_credit", bus.credit, 10);
    base = rej_seen;
    bus.vend_ack = 1'b1;
    tick();
    bus.vend_ack = 1'b0;
    check("t4_ack_credit", bus.credit, 0);
    for (int i = 0; i < 10; i++) begin
      if (bus.coin_ready) break;
      tick();
    end
    check("t4_ready_back", bus.coin_ready, 1);
    tick();
    bus.coin_valid = 1'b0;
    repeat (8) tick();
    check("t4_rejects", rej_seen - base, 2);
    check("t4_credit", bus.credit, 9);
    check("t4_no_vend", bus.vend_req, 0);

    // 5: reset during vend, with a coin buffered
    push_coin(NICKEL);
    wait_vend(10);
    push_coin(DIME);
    reset = 1'b1;
    tick();
    check("t5_vend", bus.vend_req, 0);
    check("t5_credit", bus.credit, 0);
    check("t5_change", bus.change_nickels, 0);
    check("t5_ready", bus.coin_ready, 0);
    reset = 1'b0;
    tick();
    check("t5_ready_up", bus.coin_ready, 1);
    repeat (3) tick();
    check("t5_fifo_flushed", bus.credit, 0);

    // 6: idle timeout behaviour
    push_coin(DIME);
`ifdef COIN_TIMEOUT_EN
    n = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.refund_valid) begin
        n = i;
        seen = 1'b1;
        break;
      end
    end
    check("t6_seen", seen, 1);
    check("t6_when", n, 10);
    check("t6_change", bus.change_nickels, 2);
    tick();
    check("t6_credit0", bus.credit, 0);
`else
    seen = 1'b0;
    n = 0;
    repeat (100) begin
      tick();
      if (bus.refund_valid) seen = 1'b1;
    end
    check("t6_no_refund", seen, 0);
    check("t6_credit_held", bus.credit, 2);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check("t6_cancel_change", bus.change_nickels, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
